// File: rtl/seq_divider.sv
// seq_divider: restoring sequential divider, quotient on lo_o, remainder on hi_o (SEQ_DIVIDER_SIGNED_EN enables signed_op_i); ports: clk_i, clear_i, start_i, signed_op_i, dividend_i, divisor_i -> lo_o, hi_o, busy_o, done_o, div_by_zero_o
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic             signed_op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o
);
  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, lo_q, lo_d, hi_q, hi_d;
  logic [WIDTH:0] rem_q, rem_d, rem_sh;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d, dbz_q, dbz_d, ge;
  logic [WIDTH-1:0] mag_a, mag_b, q_fix, r_fix;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sop_q, qneg_q, rneg_q, neg_a, neg_b;
  assign neg_a = sop_q & dvd_q[WIDTH-1];
  assign neg_b = sop_q & dvs_q[WIDTH-1];
  assign mag_a = neg_a ? -dvd_q : dvd_q;
  assign mag_b = neg_b ? -dvs_q : dvs_q;
  assign q_fix = qneg_q ? -dvd_q : dvd_q;
  assign r_fix = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  always_ff @(posedge clk_i or posedge clear_i)
    if (clear_i) begin
      sop_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (state_q == IDLE && start_i) begin
      sop_q  <= signed_op_i;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (state_q == PREP) begin
      qneg_q <= neg_a ^ neg_b;
      rneg_q <= neg_a;
    end
`else
  logic unused_sop;
  assign unused_sop = signed_op_i;
  assign mag_a = dvd_q;
  assign mag_b = dvs_q;
  assign q_fix = dvd_q;
  assign r_fix = rem_q[WIDTH-1:0];
`endif
  // dvd_q holds the dividend, then its magnitude, then shifts into the quotient
  assign rem_sh = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign ge     = rem_sh >= {1'b0, dvs_q};
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    busy_d  = busy_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        dvd_d   = dividend_i;
        dvs_d   = divisor_i;
        rem_d   = '0;
        busy_d  = 1'b1;
        dbz_d   = divisor_i == '0;
        // zero-divide dwells one cycle in FIX so done lands two edges after start
        cnt_d   = CNT_W'(1);
        state_d = (divisor_i == '0) ? FIX : PREP;
      end
      PREP: begin
        dvd_d   = mag_a;
        dvs_d   = mag_b;
        rem_d   = '0;
        cnt_d   = CNT_W'(WIDTH - 1);
        state_d = ITER;
      end
      ITER: begin
        rem_d   = ge ? rem_sh - {1'b0, dvs_q} : rem_sh;
        dvd_d   = {dvd_q[WIDTH-2:0], ge};
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? FIX : ITER;
      end
      FIX: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else begin
        lo_d    = dbz_q ? '1 : q_fix;
        hi_d    = dbz_q ? dvd_q : r_fix;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge clear_i)
    if (clear_i) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  assign lo_o          = lo_q;
  assign hi_o          = hi_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven check of seq_divider at WIDTH=32 and WIDTH=8
module tb_seq_divider;
  logic clk = 1'b0, clear = 1'b0;
  always #5 clk = ~clk;
  logic st32 = 0, sg32 = 0, st8 = 0, sg8 = 0;
  logic [31:0] a32 = 0, b32 = 0, lo32, hi32;
  logic [7:0] a8 = 0, b8 = 0, lo8, hi8;
  logic by32, dn32, bz32, by8, dn8, bz8;
  seq_divider #(.WIDTH(32), .CNT_W(6)) u32 (
    .clk_i(clk), .clear_i(clear), .start_i(st32), .signed_op_i(sg32),
    .dividend_i(a32), .divisor_i(b32), .lo_o(lo32), .hi_o(hi32),
    .busy_o(by32), .done_o(dn32), .div_by_zero_o(bz32));
  seq_divider #(.WIDTH(8), .CNT_W(4)) u8 (
    .clk_i(clk), .clear_i(clear), .start_i(st8), .signed_op_i(sg8),
    .dividend_i(a8), .divisor_i(b8), .lo_o(lo8), .hi_o(hi8),
    .busy_o(by8), .done_o(dn8), .div_by_zero_o(bz8));
  int checks = 0, failures = 0;
  bit sel = 0;
  logic [31:0] lo_m, hi_m;
  logic dn_m, by_m, bz_m;
  always_comb begin
    lo_m = sel ? {24'h0, lo8} : lo32;
    hi_m = sel ? {24'h0, hi8} : hi32;
    dn_m = sel ? dn8 : dn32;
    by_m = sel ? by8 : by32;
    bz_m = sel ? bz8 : bz32;
  end
  typedef struct {
    bit          w8;
    bit          sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    bit          bz;
    int          lat;
  } vec_t;
  vec_t vt[12];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic run(input int id, input vec_t v);
    int n;
    sel = v.w8;
    @(negedge clk);
    if (v.w8) begin
      a8 = v.a[7:0]; b8 = v.b[7:0]; sg8 = v.sg; st8 = 1;
    end else begin
      a32 = v.a; b32 = v.b; sg32 = v.sg; st32 = 1;
    end
    @(posedge clk); #1;
    st8 = 0; st32 = 0;
    a8 = 8'h5A; b8 = 8'h0; a32 = 32'h1234_5678; b32 = 32'h0;
    chk($sformatf("v%0d busy", id), {31'h0, by_m}, 32'd1);
    chk($sformatf("v%0d done_low", id), {31'h0, dn_m}, 32'd0);
    n = 0;
    while (!dn_m && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("v%0d latency", id), n, v.lat);
    chk($sformatf("v%0d lo", id), lo_m, v.lo);
    chk($sformatf("v%0d hi", id), hi_m, v.hi);
    chk($sformatf("v%0d dbz", id), {31'h0, bz_m}, {31'h0, v.bz});
    chk($sformatf("v%0d busy_at_done", id), {31'h0, by_m}, 32'd0);
  endtask
  initial begin
    int n, pulses;
    logic [7:0] cap_lo, cap_hi;
    vt[0]  = '{0, 0, 32'h8FFFFFFF, 32'h3, 32'h2FFFFFFF, 32'h2, 0, 34};
`ifdef SEQ_DIVIDER_SIGNED_EN
    vt[1]  = '{0, 1, 32'h8FFFFFFF, 32'h3, 32'hDAAAAAAB, 32'hFFFFFFFE, 0, 34};
    vt[4]  = '{0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 0, 34};
    vt[6]  = '{0, 1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 34};
    vt[9]  = '{0, 1, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1, 0, 34};
    vt[11] = '{1, 1, 32'h80, 32'hFF, 32'h80, 32'h0, 0, 10};
`else
    vt[1]  = '{0, 1, 32'h8FFFFFFF, 32'h3, 32'h2FFFFFFF, 32'h2, 0, 34};
    vt[4]  = '{0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0, 34};
    vt[6]  = '{0, 1, 32'hFFFFFFF9, 32'h2, 32'h7FFFFFFC, 32'h1, 0, 34};
    vt[9]  = '{0, 1, 32'h7, 32'hFFFFFFFE, 32'h0, 32'h7, 0, 34};
    vt[11] = '{1, 1, 32'h80, 32'hFF, 32'h0, 32'h80, 0, 10};
`endif
    vt[2]  = '{0, 0, 32'h27, 32'h0, 32'hFFFFFFFF, 32'h27, 1, 2};
    vt[3]  = '{0, 0, 32'h27, 32'h7, 32'h5, 32'h4, 0, 34};
    vt[5]  = '{0, 1, 32'h27, 32'h0, 32'hFFFFFFFF, 32'h27, 1, 2};
    vt[7]  = '{0, 0, 32'h5, 32'h9, 32'h0, 32'h5, 0, 34};
    vt[8]  = '{0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 34};
    vt[10] = '{1, 0, 32'h27, 32'h0, 32'hFF, 32'h27, 1, 2};
    #1 clear = 1;
    #2;
    chk("reset lo32", lo32, 0);
    chk("reset hi32", hi32, 0);
    chk("reset flags32", {29'h0, by32, dn32, bz32}, 0);
    chk("reset flags8", {29'h0, by8, dn8, bz8}, 0);
    @(negedge clk) clear = 0;
    // 8-bit 0x27/0x07 with a second start while busy
    sel = 1;
    @(negedge clk);
    a8 = 8'h27; b8 = 8'h07; sg8 = 0; st8 = 1;
    @(posedge clk); #1;
    st8 = 0;
    n = 0; pulses = 0; cap_lo = 0; cap_hi = 0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 3) begin
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; st8 = 1;
      end
      @(posedge clk); #1;
      st8 = 0;
      if (dn8) begin
        pulses++;
        if (pulses == 1) begin
          n = i; cap_lo = lo8; cap_hi = hi8;
        end
      end
    end
    chk("busy_ignore pulses", pulses, 1);
    chk("busy_ignore latency", n, 10);
    chk("busy_ignore lo", {24'h0, cap_lo}, 32'h05);
    chk("busy_ignore hi", {24'h0, cap_hi}, 32'h04);
    for (int i = 0; i < 12; i++) run(i, vt[i]);
    repeat (3) @(posedge clk);
    #1;
    chk("hold lo", lo_m, vt[11].lo);
    chk("hold hi", hi_m, vt[11].hi);
    chk("hold done", {31'h0, dn_m}, 0);
    // abort mid-iteration with an asynchronous Clear pulse
    sel = 0;
    @(negedge clk);
    a32 = 32'h8FFFFFFF; b32 = 32'h3; sg32 = 0; st32 = 1;
    @(posedge clk); #1;
    st32 = 0;
    repeat (11) @(posedge clk);
    #2 clear = 1;
    #1;
    chk("abort lo", lo32, 0);
    chk("abort hi", hi32, 0);
    chk("abort flags", {29'h0, by32, dn32, bz32}, 0);
    #4 clear = 0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (dn32) pulses++;
    end
    chk("abort no_done", pulses, 0);
    run(12, '{0, 0, 32'h27, 32'h7, 32'h5, 32'h4, 0, 34});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
